regfile_scoreboard_8x16: RTL and testbench
==========================================

Name: regfile_scoreboard_8x16

Overview:
- 8-entry × 16-bit general-purpose register file for the pipelined datapath, built from per-entry 16-bit storage with write enable.
- Provides two combinational read ports and one clocked write port.
- Adds a per-register busy scoreboard: decode marks a destination busy at issue, and writeback clears it. Hazard logic consumes the busy flags to stall.

Parameters:
- WIDTH, 16, data width of each register.
- NREGS, 8, number of registers.
- SELW, 3, register-select width; log2(NREGS).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- read1regsel  input  SELW  read port 1 register select.
- read2regsel  input  SELW  read port 2 register select.
- writeregsel  input  SELW  writeback destination select.
- writedata  input  WIDTH  writeback data.
- write  input  1  writeback enable.
- issue_valid  input  1  decode issues an instruction that writes issue_reg.
- issue_reg  input  SELW  destination being issued.
- read1data  output  WIDTH  contents of read1regsel.
- read2data  output  WIDTH  contents of read2regsel.
- busy1  output  1  busy bit of read1regsel.
- busy2  output  1  busy bit of read2regsel.
- busy_cnt  output  SELW+1  number of busy registers (registered).
- err  output  1  illegal issue this cycle (combinational).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While rst=0, all registers, all busy bits and busy_cnt are 0 immediately, independent of clk.
- Reset outputs: read1data and read2data show 0 during reset; busy1=busy2=0; err=0.
- Reset mid-operation: any pending issue or write in that cycle is discarded, and busy bits are cleared.
- Write:
  - On a rising edge with write=1, reg[writeregsel] <= writedata.
  - Otherwise every register holds its value.
  - Register 0 is an ordinary writable register.
- Read:
  - Reads are combinational, with zero-cycle latency.
  - Without bypass, a same-cycle write is visible only after the edge.
- Scoreboard update (per bit i, at the rising edge):
  - set_i = issue_valid && issue_reg==i.
  - clr_i = write && writeregsel==i.
  - set_i and clr_i: busy stays 1 (the new producer supersedes the old one).
  - set_i only: busy <= 1.
  - clr_i only: busy <= 0.
  - Neither: hold.
- Writing a non-busy register is legal; busy stays 0 and err is not raised.
- busy1/busy2: busy[read1regsel] and busy[read2regsel], read from the current registered state.
- busy_cnt:
  - Equals the population count of the next busy vector, registered at the same edge.
  - Range is 0..NREGS; it never wraps, because the count is recomputed, not incremented.
- err:
  - err = issue_valid && busy[issue_reg] && !(write && writeregsel==issue_reg).
  - This flags a second issue to a register with an outstanding writer.
  - The state update still proceeds (busy remains 1); err does not block it.
- Simultaneous read1regsel==read2regsel: both ports return identical data and busy values.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - If write=1 and writeregsel==readNregsel, then readNdata = writedata in the same cycle.
  - The matching busyN also reads 0 in that cycle, unless issue_valid && issue_reg==readNregsel in that same cycle.
- Undefined:
  - No bypass; reads return the stored value, and busyN reflects the registered state only.
- Scoreboard and err are identical in both builds.

Test Plan:
- Reset check: assert rst=0 mid-cycle after writing 0xBEEF to r3. Required: read1data (sel=3) = 0x0000 immediately, busy_cnt=0, err=0.
- Write/read:
  - Write 0x1234 to r5 with write=1 for one edge, then read1regsel=5 and read2regsel=5. Required: both ports 0x1234.
  - Write 0xFFFF to r5 with write=0. Required: r5 still 0x1234.
- Scoreboard:
  - Issue r2. Required: next cycle busy1 (sel=2) = 1 and busy_cnt=1.
  - Write r2 = 0x00A0. Required: next cycle busy1=0, busy_cnt=0, and read 0x00A0.
- Simultaneous events:
  - With r4 busy, apply issue r4 and write r4 = 0x0042 in the same cycle. Required: err=0, r4 stays busy, data 0x0042.
  - Issue r4 again with no write. Required: err=1 that cycle, busy_cnt unchanged.
- Saturation: issue r0..r7 on 8 consecutive cycles. Required: busy_cnt reaches 8 (0b1000) and holds; then writing r7 gives 7.
- Bypass: same-cycle write 0x5A5A to r1 with read1regsel=1.
  - With REGFILE_BYPASS_EN: read1data=0x5A5A in that cycle.
  - Without it: the old value that cycle, 0x5A5A after the edge.

Source files
------------

// File: rtl/regfile_scoreboard_8x16.sv
// regfile_scoreboard_8x16
//   8-entry x 16-bit register file with two combinational read ports, one
//   clocked write port and a per-register busy scoreboard. Decode sets a
//   destination's busy bit at issue and writeback clears it. Hazard logic
//   reads busy1/busy2 to decide whether to stall.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a same-cycle write is forwarded to a matching read port.
//   The matching busy flag is forwarded too. When undefined, reads and busy
//   flags show registered state only.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   read1regsel  read port 1 select      -> read1data, busy1
//   read2regsel  read port 2 select      -> read2data, busy2
//   writeregsel  writeback destination
//   writedata    writeback data
//   write        writeback enable (also clears the destination's busy bit)
//   issue_valid  decode issues a writer of issue_reg (sets its busy bit)
//   issue_reg    destination being issued
//   busy_cnt     registered population count of the busy vector
//   err          combinational: issue to a register that already has a writer
module regfile_scoreboard_8x16 #(
   parameter int WIDTH = 16,
   parameter int NREGS = 8,
   parameter int SELW  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SELW-1:0]  read1regsel,
   input  logic [SELW-1:0]  read2regsel,
   input  logic [SELW-1:0]  writeregsel,
   input  logic [WIDTH-1:0] writedata,
   input  logic             write,
   input  logic             issue_valid,
   input  logic [SELW-1:0]  issue_reg,
   output logic [WIDTH-1:0] read1data,
   output logic [WIDTH-1:0] read2data,
   output logic             busy1,
   output logic             busy2,
   output logic [SELW:0]    busy_cnt,
   output logic             err
);

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [SELW:0]    busy_cnt_q;
   logic [SELW:0]    busy_cnt_d;

   // The count is recomputed from the vector every cycle, so it can never wrap.
   function automatic logic [SELW:0] popcount(input logic [NREGS-1:0] v);
      logic [SELW:0] cnt;
      cnt = '0;
      for (int i = 0; i < NREGS; i++) begin
         cnt = cnt + {{SELW{1'b0}}, v[i]};
      end
      return cnt;
   endfunction

   // Next-state: storage, scoreboard and count.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (write) begin
         regs_d[writeregsel] = writedata;
      end
      // An issue in the same cycle as a writeback wins, because the new
      // producer supersedes the one being retired.
      for (int i = 0; i < NREGS; i++) begin
         if (issue_valid && (issue_reg == SELW'(i))) begin
            busy_d[i] = 1'b1;
         end else if (write && (writeregsel == SELW'(i))) begin
            busy_d[i] = 1'b0;
         end
      end
      busy_cnt_d = popcount(busy_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   // Read ports. Outputs are forced to 0 while reset is asserted, so a
   // forwarded write cannot leak through during reset.
   always_comb begin
      read1data = '0;
      read2data = '0;
      busy1     = 1'b0;
      busy2     = 1'b0;
      err       = 1'b0;
      if (rst) begin
         read1data = regs_q[read1regsel];
         read2data = regs_q[read2regsel];
         busy1     = busy_q[read1regsel];
         busy2     = busy_q[read2regsel];
`ifdef REGFILE_BYPASS_EN
         // A forwarded port sees the post-edge busy bit. That bit is 0 unless
         // an issue to the same register arrives in this cycle.
         if (write && (writeregsel == read1regsel)) begin
            read1data = writedata;
            busy1     = busy_d[read1regsel];
         end
         if (write && (writeregsel == read2regsel)) begin
            read2data = writedata;
            busy2     = busy_d[read2regsel];
         end
`endif
         err = issue_valid && busy_q[issue_reg] &&
               !(write && (writeregsel == issue_reg));
      end
   end

   assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard_8x16.sv
module tb_regfile_scoreboard_8x16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  read1regsel = '0;
   logic [2:0]  read2regsel = '0;
   logic [2:0]  writeregsel = '0;
   logic [15:0] writedata = '0;
   logic        write = 1'b0;
   logic        issue_valid = 1'b0;
   logic [2:0]  issue_reg = '0;
   logic [15:0] read1data;
   logic [15:0] read2data;
   logic        busy1;
   logic        busy2;
   logic [3:0]  busy_cnt;
   logic        err;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   regfile_scoreboard_8x16 dut (
      .clk         (clk),
      .rst         (rst),
      .read1regsel (read1regsel),
      .read2regsel (read2regsel),
      .writeregsel (writeregsel),
      .writedata   (writedata),
      .write       (write),
      .issue_valid (issue_valid),
      .issue_reg   (issue_reg),
      .read1data   (read1data),
      .read2data   (read2data),
      .busy1       (busy1),
      .busy2       (busy2),
      .busy_cnt    (busy_cnt),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Model state: plain arrays of values and busy flags.
   int m_val  [8];
   bit m_busy [8];
   int m_cnt;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) begin
            m_val[i]  = 0;
            m_busy[i] = 0;
         end
         m_cnt = 0;
      end else begin
         if (write) begin
            m_val[writeregsel] = writedata;
            m_busy[writeregsel] = 0;
         end
         if (issue_valid) m_busy[issue_reg] = 1;
         m_cnt = 0;
         for (int i = 0; i < 8; i++) m_cnt += m_busy[i];
      end
   end

   function automatic int exp_data(input logic [2:0] sel);
      if (!rst) return 0;
`ifdef REGFILE_BYPASS_EN
      if (write && writeregsel == sel) return writedata;
`endif
      return m_val[sel];
   endfunction

   function automatic bit exp_busy(input logic [2:0] sel);
      if (!rst) return 0;
`ifdef REGFILE_BYPASS_EN
      if (write && writeregsel == sel) return issue_valid && issue_reg == sel;
`endif
      return m_busy[sel];
   endfunction

   function automatic bit exp_err();
      if (!rst) return 0;
      return issue_valid && m_busy[issue_reg] && !(write && writeregsel == issue_reg);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_on) begin
         check("m_read1data", int'(read1data), exp_data(read1regsel));
         check("m_read2data", int'(read2data), exp_data(read2regsel));
         check("m_busy1", int'(busy1), int'(exp_busy(read1regsel)));
         check("m_busy2", int'(busy2), int'(exp_busy(read2regsel)));
         check("m_busy_cnt", int'(busy_cnt), m_cnt);
         check("m_err", int'(err), int'(exp_err()));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      cmp_on = 1'b1;
      step();
      step();
      rst = 1'b1;
      step();

      // Reset mid-operation.
      write = 1; writeregsel = 3; writedata = 16'hBEEF;
      step();
      write = 0; read1regsel = 3;
      #1 check("wr_beef", int'(read1data), 16'hBEEF);
      issue_valid = 1; issue_reg = 3;
      step();
      issue_valid = 0;
      check("pre_rst_cnt", int'(busy_cnt), 1);
      #2 rst = 1'b0;
      #1;
      check("rst_read1", int'(read1data), 0);
      check("rst_cnt", int'(busy_cnt), 0);
      check("rst_err", int'(err), 0);
      check("rst_busy1", int'(busy1), 0);
      step();
      rst = 1'b1;
      step();

      // Write and read.
      write = 1; writeregsel = 5; writedata = 16'h1234;
      step();
      write = 0; read1regsel = 5; read2regsel = 5;
      #1;
      check("rd1_r5", int'(read1data), 16'h1234);
      check("rd2_r5", int'(read2data), 16'h1234);
      writedata = 16'hFFFF;
      step();
      check("no_write_r5", int'(read1data), 16'h1234);

      // Scoreboard issue and clear.
      issue_valid = 1; issue_reg = 2;
      step();
      issue_valid = 0; read1regsel = 2;
      #1;
      check("busy_r2", int'(busy1), 1);
      check("cnt_r2", int'(busy_cnt), 1);
      write = 1; writeregsel = 2; writedata = 16'h00A0;
      step();
      write = 0;
      check("busy_r2_clr", int'(busy1), 0);
      check("cnt_r2_clr", int'(busy_cnt), 0);
      check("rd_r2", int'(read1data), 16'h00A0);

      // Simultaneous issue and write on a busy register.
      issue_valid = 1; issue_reg = 4;
      step();
      read1regsel = 4; write = 1; writeregsel = 4; writedata = 16'h0042;
      #1 check("err_same_cycle", int'(err), 0);
      step();
      issue_valid = 0; write = 0;
      check("busy_r4_kept", int'(busy1), 1);
      check("rd_r4", int'(read1data), 16'h0042);
      check("cnt_r4", int'(busy_cnt), 1);
      issue_valid = 1; issue_reg = 4;
      #1 check("err_reissue", int'(err), 1);
      step();
      issue_valid = 0;
      check("cnt_after_err", int'(busy_cnt), 1);

      // Fill every register.
      for (int i = 0; i < 8; i++) begin
         issue_valid = 1; issue_reg = 3'(i);
         step();
      end
      issue_valid = 0;
      check("cnt_full", int'(busy_cnt), 8);
      step();
      check("cnt_full_hold", int'(busy_cnt), 8);
      write = 1; writeregsel = 7; writedata = 16'h0777;
      step();
      write = 0;
      check("cnt_after_w7", int'(busy_cnt), 7);

      // Same-cycle write and read of r1, which holds 0 since reset.
      read1regsel = 1; read2regsel = 6;
      write = 1; writeregsel = 1; writedata = 16'h5A5A;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("bypass_same_cycle", int'(read1data), 16'h5A5A);
`else
      check("bypass_same_cycle", int'(read1data), 0);
`endif
      step();
      write = 0;
      check("r1_after_edge", int'(read1data), 16'h5A5A);

      // Free-running directed mix, checked by the model only.
      for (int i = 0; i < 16; i++) begin
         write = i[0]; writeregsel = 3'(i * 3); writedata = 16'(i * 16'h1111);
         issue_valid = i[1]; issue_reg = 3'(i * 5);
         read1regsel = 3'(i); read2regsel = 3'(i * 3);
         step();
      end
      write = 0; issue_valid = 0;
      step();
      cmp_on = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
